// File: rtl/risc_v_isa_pkg.sv
// RV32I encoding types, decoded-record layout and the shared instruction decoder.
package risc_v_isa_pkg;

    localparam int unsigned INFO_W = 64;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // funct7 / imm[11:5] values selecting the logical vs arithmetic variant
    localparam logic [6:0] SHIFT_F7_SRL = 7'h00;
    localparam logic [6:0] SHIFT_F7_SRA = 7'h20;

    typedef struct packed { logic [6:0] funct7; logic [4:0] rs2; logic [4:0] rs1;
                            logic [2:0] funct3; logic [4:0] rd; logic [6:0] opcode; } r_fmt_t;
    typedef struct packed { logic [11:0] imm; logic [4:0] rs1; logic [2:0] funct3;
                            logic [4:0] rd; logic [6:0] opcode; } i_fmt_t;
    typedef struct packed { logic [6:0] imm_11_5; logic [4:0] rs2; logic [4:0] rs1;
                            logic [2:0] funct3; logic [4:0] imm_4_0; logic [6:0] opcode; } s_fmt_t;
    typedef struct packed { logic imm_12; logic [5:0] imm_10_5; logic [4:0] rs2; logic [4:0] rs1;
                            logic [2:0] funct3; logic [3:0] imm_4_1; logic imm_11; logic [6:0] opcode; } b_fmt_t;
    typedef struct packed { logic [19:0] imm_31_12; logic [4:0] rd; logic [6:0] opcode; } u_fmt_t;
    typedef struct packed { logic imm_20; logic [9:0] imm_10_1; logic imm_11; logic [7:0] imm_19_12;
                            logic [4:0] rd; logic [6:0] opcode; } j_fmt_t;

    typedef union packed { r_fmt_t r; i_fmt_t i; s_fmt_t s; b_fmt_t b; u_fmt_t u; j_fmt_t j; } instr_u;

    typedef enum logic [31:0] {
        IT_ALU = 32'd0, IT_MEM = 32'd1, IT_BRN = 32'd2, IT_JMP = 32'd3, IT_LUP = 32'd4, IT_ENV = 32'd5
    } i_type_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ = 3'd0, BR_NE = 3'd1, BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7
    } brn_cond_e;

    // Every per-type command view is exactly 32 bits; padding stays zero
    typedef struct packed { alu_op_e op; logic use_immediate; logic [4:0] rd; logic [4:0] rs1;
                            logic [4:0] rs2; logic [11:0] imm; } alu_cmd_t;
    typedef struct packed { logic load_op; logic [2:0] size; logic [4:0] rd; logic [4:0] rs1;
                            logic [4:0] rs2; logic [11:0] addr_offset; logic rsvd; } mem_cmd_t;
    typedef struct packed { logic [5:0] rsvd; brn_cond_e cond; logic [4:0] rs1; logic [4:0] rs2;
                            logic [12:0] imm; } brn_cmd_t;
    typedef struct packed { logic use_src_reg; logic [4:0] rd; logic [4:0] rs1; logic [20:0] imm; } jmp_cmd_t;
    typedef struct packed { logic [5:0] rsvd; logic incr_pc; logic [4:0] rd; logic [19:0] imm; } lup_cmd_t;
    typedef struct packed { logic [29:0] rsvd; logic is_call; logic is_break; } env_cmd_t;

    typedef union packed { alu_cmd_t alu; mem_cmd_t mem; brn_cmd_t brn; jmp_cmd_t jmp;
                           lup_cmd_t lup; env_cmd_t env; } cmd_u;

    typedef struct packed { cmd_u cmd; i_type_e i_type; } instrInfo_s;

    typedef struct packed { instrInfo_s info; logic illegal; } dec_res_t;

    function automatic alu_op_e alu_op_of(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_res_t decode_instr(input instr_u instr);
        dec_res_t res;
        logic     ill;
        logic     shift;
        res   = '0;
        ill   = 1'b0;
        shift = 1'b0;
        case (instr.r.opcode)
            OPC_OP: begin
                res.info.i_type        = IT_ALU;
                res.info.cmd.alu.op    = alu_op_of(instr.r.funct3, instr.r.funct7 == SHIFT_F7_SRA);
                res.info.cmd.alu.rd    = instr.r.rd;
                res.info.cmd.alu.rs1   = instr.r.rs1;
                res.info.cmd.alu.rs2   = instr.r.rs2;
                ill = !(instr.r.funct7 == SHIFT_F7_SRL ||
                        (instr.r.funct7 == SHIFT_F7_SRA && (instr.r.funct3 == 3'd0 || instr.r.funct3 == 3'd5)));
            end
            OPC_OP_IMM: begin
                shift = (instr.i.funct3 == 3'd1) || (instr.i.funct3 == 3'd5);
                res.info.i_type                = IT_ALU;
                res.info.cmd.alu.op            = alu_op_of(instr.i.funct3,
                                                           shift && instr.i.imm[11:5] == SHIFT_F7_SRA);
                res.info.cmd.alu.use_immediate = 1'b1;
                res.info.cmd.alu.rd            = instr.i.rd;
                res.info.cmd.alu.rs1           = instr.i.rs1;
                res.info.cmd.alu.imm           = instr.i.imm;
                if (shift) begin
                    res.info.cmd.alu.imm[11:5] = '0;
                    ill = !(instr.i.imm[11:5] == SHIFT_F7_SRL ||
                            (instr.i.funct3 == 3'd5 && instr.i.imm[11:5] == SHIFT_F7_SRA));
                end
            end
            OPC_LOAD: begin
                res.info.i_type               = IT_MEM;
                res.info.cmd.mem.load_op      = 1'b1;
                res.info.cmd.mem.size         = instr.i.funct3;
                res.info.cmd.mem.rd           = instr.i.rd;
                res.info.cmd.mem.rs1          = instr.i.rs1;
                res.info.cmd.mem.addr_offset  = instr.i.imm;
                ill = (instr.i.funct3 == 3'd3) || (instr.i.funct3 >= 3'd6);
            end
            OPC_STORE: begin
                res.info.i_type               = IT_MEM;
                res.info.cmd.mem.size         = instr.s.funct3;
                res.info.cmd.mem.rs1          = instr.s.rs1;
                res.info.cmd.mem.rs2          = instr.s.rs2;
                res.info.cmd.mem.addr_offset  = {instr.s.imm_11_5, instr.s.imm_4_0};
                ill = instr.s.funct3 > 3'd2;
            end
            OPC_BRANCH: begin
                res.info.i_type        = IT_BRN;
                res.info.cmd.brn.cond  = brn_cond_e'(instr.b.funct3);
                res.info.cmd.brn.rs1   = instr.b.rs1;
                res.info.cmd.brn.rs2   = instr.b.rs2;
                res.info.cmd.brn.imm   = {instr.b.imm_12, instr.b.imm_11, instr.b.imm_10_5, instr.b.imm_4_1, 1'b0};
                ill = (instr.b.funct3 == 3'd2) || (instr.b.funct3 == 3'd3);
            end
            OPC_JAL: begin
                res.info.i_type        = IT_JMP;
                res.info.cmd.jmp.rd    = instr.j.rd;
                res.info.cmd.jmp.imm   = {instr.j.imm_20, instr.j.imm_19_12, instr.j.imm_11, instr.j.imm_10_1, 1'b0};
            end
            OPC_JALR: begin
                res.info.i_type              = IT_JMP;
                res.info.cmd.jmp.use_src_reg = 1'b1;
                res.info.cmd.jmp.rd          = instr.i.rd;
                res.info.cmd.jmp.rs1         = instr.i.rs1;
                res.info.cmd.jmp.imm         = {{9{instr.i.imm[11]}}, instr.i.imm};
                ill = instr.i.funct3 != 3'd0;
            end
            OPC_LUI, OPC_AUIPC: begin
                res.info.i_type          = IT_LUP;
                res.info.cmd.lup.incr_pc = (instr.u.opcode == OPC_AUIPC);
                res.info.cmd.lup.rd      = instr.u.rd;
                res.info.cmd.lup.imm     = instr.u.imm_31_12;
            end
            OPC_SYSTEM: begin
                res.info.i_type = IT_ENV;
                if (instr.i.funct3 != 3'd0 || instr.i.rd != 5'd0 || instr.i.rs1 != 5'd0) ill = 1'b1;
                else if (instr.i.imm == 12'd0) res.info.cmd.env.is_call = 1'b1;
                else if (instr.i.imm == 12'd1) res.info.cmd.env.is_break = 1'b1;
                else ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            res.info        = '0;
            res.info.i_type = IT_ENV;
        end
        res.illegal = ill;
        return res;
    endfunction

endpackage

// File: rtl/risc_v_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, ready driven only from a flop.
module risc_v_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         ready_q;
    logic         in_fire;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire      = in_valid_i & ready_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            // Output slot frees this edge: skid has priority to keep order
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) out_data_d = in_data_i;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/risc_v_decode_stage.sv
// RV32I decode stage: combinational decode into a skid-buffered valid/ready pipe, plus a handover counter.
module risc_v_decode_stage
    import risc_v_isa_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [INFO_W-1:0] dec_info_o,
    output logic [PC_W-1:0]   dec_pc_o,
    output logic              dec_illegal_o,
    output logic [CNT_W-1:0]  dec_count_o
);

    localparam int unsigned BUF_W = INFO_W + 1 + PC_W;

    instr_u           instr;
    dec_res_t         dec;
    logic [BUF_W-1:0] buf_in;
    logic [BUF_W-1:0] buf_out;
    logic [CNT_W-1:0] count_q, count_d;

    assign instr  = instr_i;
    assign dec    = decode_instr(instr);
    assign buf_in = {dec.info, dec.illegal, pc_i};

    risc_v_skid_buf #(.W(BUF_W)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (instr_valid_i),
        .in_ready_o  (instr_ready_o),
        .in_data_i   (buf_in),
        .out_valid_o (dec_valid_o),
        .out_ready_i (dec_ready_i),
        .out_data_o  (buf_out)
    );

    assign {dec_info_o, dec_illegal_o, dec_pc_o} = buf_out;

    // A handover in a flush cycle still counts
    always_comb begin
        count_d = count_q;
        if (dec_valid_o && dec_ready_i) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign dec_count_o = count_q;

endmodule

// File: tb/tb_risc_v_decode_stage.sv
// Bench for risc_v_decode_stage: directed and random steps checked against a queue-based reference.
module tb_risc_v_decode_stage;
    import risc_v_isa_pkg::*;

    typedef struct packed { logic [63:0] info; logic ill; logic [31:0] pc; } rec_t;

    logic        clk = 1'b0;
    logic        rst, flush_i, instr_valid_i, instr_ready_o, dec_valid_o, dec_ready_i, dec_illegal_o;
    logic [31:0] instr_i, pc_i, dec_pc_o;
    logic [63:0] dec_info_o;
    logic [15:0] dec_count_o;

    rec_t        m_q[$];
    logic [15:0] m_cnt = '0;
    int          passes = 0;
    int          total = 0;
    instrInfo_s  di;
    logic [31:0] ws [4];
    logic [15:0] cnt0;
    int          idx;

    risc_v_decode_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .instr_i(instr_i), .pc_i(pc_i), .dec_valid_o(dec_valid_o),
        .dec_ready_i(dec_ready_i), .dec_info_o(dec_info_o), .dec_pc_o(dec_pc_o),
        .dec_illegal_o(dec_illegal_o), .dec_count_o(dec_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference decode written straight from the RV32I field rules
    function automatic rec_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        instrInfo_s x;
        logic       ill;
        rec_t       r;
        alu_op_e    base [8];
        logic [6:0] opc, f7;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [11:0] imm_i;
        base  = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        opc = w[6:0]; rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
        imm_i = w[31:20];
        x = '0; ill = 1'b0;
        if (opc == 7'h33) begin
            x.i_type = IT_ALU; x.cmd.alu.rd = rd; x.cmd.alu.rs1 = rs1; x.cmd.alu.rs2 = rs2;
            x.cmd.alu.op = base[f3];
            if (f7 == 7'h20 && f3 == 3'd0) x.cmd.alu.op = ALU_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) x.cmd.alu.op = ALU_SRA;
            ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (opc == 7'h13) begin
            x.i_type = IT_ALU; x.cmd.alu.use_immediate = 1'b1; x.cmd.alu.rd = rd; x.cmd.alu.rs1 = rs1;
            x.cmd.alu.imm = imm_i; x.cmd.alu.op = base[f3];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                x.cmd.alu.imm = {7'h00, imm_i[4:0]};
                if (f3 == 3'd5 && f7 == 7'h20) x.cmd.alu.op = ALU_SRA;
                else if (f7 != 7'h00) ill = 1'b1;
            end
        end else if (opc == 7'h03) begin
            x.i_type = IT_MEM; x.cmd.mem.load_op = 1'b1; x.cmd.mem.size = f3; x.cmd.mem.rd = rd;
            x.cmd.mem.rs1 = rs1; x.cmd.mem.addr_offset = imm_i;
            ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end else if (opc == 7'h23) begin
            x.i_type = IT_MEM; x.cmd.mem.size = f3; x.cmd.mem.rs1 = rs1; x.cmd.mem.rs2 = rs2;
            x.cmd.mem.addr_offset = {w[31:25], w[11:7]};
            ill = !(f3 inside {3'd0, 3'd1, 3'd2});
        end else if (opc == 7'h63) begin
            x.i_type = IT_BRN; x.cmd.brn.cond = brn_cond_e'(f3); x.cmd.brn.rs1 = rs1; x.cmd.brn.rs2 = rs2;
            x.cmd.brn.imm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            ill = (f3 == 3'd2 || f3 == 3'd3);
        end else if (opc == 7'h6F) begin
            x.i_type = IT_JMP; x.cmd.jmp.rd = rd;
            x.cmd.jmp.imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        end else if (opc == 7'h67) begin
            x.i_type = IT_JMP; x.cmd.jmp.use_src_reg = 1'b1; x.cmd.jmp.rd = rd; x.cmd.jmp.rs1 = rs1;
            x.cmd.jmp.imm = {{9{w[31]}}, imm_i};
            ill = (f3 != 3'd0);
        end else if (opc == 7'h37 || opc == 7'h17) begin
            x.i_type = IT_LUP; x.cmd.lup.incr_pc = (opc == 7'h17); x.cmd.lup.rd = rd; x.cmd.lup.imm = w[31:12];
        end else if (opc == 7'h73) begin
            x.i_type = IT_ENV;
            if (f3 == 3'd0 && rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) x.cmd.env.is_call = 1'b1;
            else if (f3 == 3'd0 && rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd1) x.cmd.env.is_break = 1'b1;
            else ill = 1'b1;
        end else begin
            ill = 1'b1;
        end
        if (ill) begin
            x = '0; x.i_type = IT_ENV;
        end
        r.info = x; r.ill = ill; r.pc = pc;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;  9: w[6:0] = 7'h73;  10: w[6:0] = 7'h73;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            w[19:7]  = '0;
            w[31:21] = '0;
        end
        return w;
    endfunction

    // One clock: drive, advance the reference on the edge, then compare
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic dr, input logic fl, input logic r);
        logic acc, ho;
        rec_t e;
        instr_valid_i = v; instr_i = w; pc_i = pc; dec_ready_i = dr; flush_i = fl; rst = r;
        acc = v && (m_q.size() < 2);
        ho  = dr && (m_q.size() > 0);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_cnt = '0;
        end else begin
            if (ho) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (fl) m_q.delete();
            else if (acc) m_q.push_back(ref_dec(w, pc));
        end
        #1;
        chk("ready", 64'(instr_ready_o), 64'(m_q.size() < 2));
        chk("valid", 64'(dec_valid_o), 64'(m_q.size() > 0));
        chk("count", 64'(dec_count_o), 64'(m_cnt));
        if (m_q.size() > 0) begin
            e = m_q[0];
            chk("info", dec_info_o, e.info);
            chk("illegal", 64'(dec_illegal_o), 64'(e.ill));
            chk("pc", 64'(dec_pc_o), 64'(e.pc));
        end
    endtask

    initial begin
        step(0, 32'h0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        chk("rst_info", dec_info_o, 64'h0);
        chk("rst_pc", 64'(dec_pc_o), 64'h0);
        chk("rst_ready", 64'(instr_ready_o), 64'h1);

        step(1, 32'h002081B3, 32'h100, 1, 0, 0);
        di = dec_info_o;
        chk("add_type", 64'(di.i_type), 64'(IT_ALU));
        chk("add_op", 64'(di.cmd.alu.op), 64'(ALU_ADD));
        chk("add_regs", 64'({di.cmd.alu.rd, di.cmd.alu.rs1, di.cmd.alu.rs2}), 64'({5'd3, 5'd1, 5'd2}));
        chk("add_ill", 64'(dec_illegal_o), 64'h0);
        step(1, 32'hFE208EE3, 32'h104, 1, 0, 0);
        chk("add_count", 64'(dec_count_o), 64'h1);
        di = dec_info_o;
        chk("beq_type", 64'(di.i_type), 64'(IT_BRN));
        chk("beq_cond", 64'(di.cmd.brn.cond), 64'(BR_EQ));
        chk("beq_imm", 64'(di.cmd.brn.imm), 64'h1FFC);
        step(1, 32'h4032D293, 32'h108, 1, 0, 0);
        di = dec_info_o;
        chk("srai_op", 64'(di.cmd.alu.op), 64'(ALU_SRA));
        chk("srai_imm", 64'(di.cmd.alu.imm), 64'h3);
        chk("srai_useimm", 64'(di.cmd.alu.use_immediate), 64'h1);
        step(1, 32'h00000000, 32'h10C, 1, 0, 0);
        chk("zero_info", dec_info_o, 64'(IT_ENV));
        chk("zero_ill", 64'(dec_illegal_o), 64'h1);
        step(1, 32'h02009093, 32'h110, 1, 0, 0);
        chk("slli_info", dec_info_o, 64'(IT_ENV));
        chk("slli_ill", 64'(dec_illegal_o), 64'h1);
        step(1, 32'h00000073, 32'h114, 1, 0, 0);
        di = dec_info_o;
        chk("ecall_type", 64'(di.i_type), 64'(IT_ENV));
        chk("ecall_call", 64'(di.cmd.env.is_call), 64'h1);
        chk("ecall_ill", 64'(dec_illegal_o), 64'h0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        // Four-word stream with the consumer stalling from the second cycle
        ws = '{32'h00100093, 32'h00200113, 32'h003001B3, 32'h00400213};
        cnt0 = m_cnt;
        step(1, ws[0], 32'h200, 1, 0, 0);
        step(1, ws[1], 32'h204, 0, 0, 0);
        step(1, ws[2], 32'h208, 0, 0, 0);
        chk("stall_ready", 64'(instr_ready_o), 64'h0);
        idx = 2;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            logic a;
            a = (m_q.size() < 2);
            step(1, ws[idx], 32'h200 + 32'(idx) * 32'd4, 1, 0, 0);
            if (a) idx++;
        end
        for (int k = 0; k < 4; k++) step(0, 32'h0, 32'h0, 1, 0, 0);
        chk("stream_cnt", 64'(dec_count_o), 64'(cnt0 + 16'd4));

        // Flush with both entries full and a word offered
        step(1, 32'h00500293, 32'h300, 0, 0, 0);
        step(1, 32'h00600313, 32'h304, 0, 0, 0);
        step(1, 32'h00700393, 32'h308, 0, 1, 0);
        chk("flush_valid", 64'(dec_valid_o), 64'h0);
        chk("flush_ready", 64'(instr_ready_o), 64'h1);
        step(0, 32'h0, 32'h0, 1, 0, 0);
        chk("flush_empty", 64'(dec_valid_o), 64'h0);
        // Flush with a handover and an acceptable word in the same cycle
        step(1, 32'h00800413, 32'h310, 0, 0, 0);
        step(1, 32'h00900493, 32'h314, 1, 1, 0);
        chk("flush_ho_valid", 64'(dec_valid_o), 64'h0);

        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, 1'b0);

        // Counter wrap
        for (int k = 0; k < 70000 && m_cnt != 16'hFFFF; k++)
            step(1, rand_instr(), $urandom, 1, 0, 0);
        step(1, rand_instr(), $urandom, 1, 0, 0);
        chk("count_wrap", 64'(dec_count_o), 64'h0);

        // Reset while the output is stalled and the skid is full
        step(1, 32'h00A00513, 32'h400, 0, 0, 0);
        step(1, 32'h00B00593, 32'h404, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 1);
        chk("rst2_valid", 64'(dec_valid_o), 64'h0);
        chk("rst2_info", dec_info_o, 64'h0);
        chk("rst2_pc", 64'(dec_pc_o), 64'h0);
        chk("rst2_ill", 64'(dec_illegal_o), 64'h0);
        chk("rst2_ready", 64'(instr_ready_o), 64'h1);
        chk("rst2_count", 64'(dec_count_o), 64'h0);
        step(0, 32'h0, 32'h0, 1, 0, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
